int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 104 ++++++++++
 tb/tb_int_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Eight-source vectored interrupt controller: edge-detected pending register, mask,
// fixed lowest-index priority, single-level service. Define INT_SYNC_EN to add 2-flop input synchronizers.
module int_ctrl #(
  parameter logic [15:0] VEC_BASE = 16'hFF00,
  parameter int          NSRC     = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_in,
  input  logic            iack,
  input  logic            eoi,
  output logic            irq,
  output logic [15:0]     vec_addr,
  output logic            in_service,
  output logic [NSRC-1:0] pending
);

  localparam int IDX_W = $clog2(NSRC);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state, state_nxt;
  logic [NSRC-1:0]   sample, prev, mask;
  logic [NSRC-1:0]   set_vec, clr_vec, active;
  logic [IDX_W-1:0]  ack_idx;
  logic              ack;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NSRC-1:0] v);
    lowest_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

`ifdef INT_SYNC_EN
  logic [NSRC-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign sample = sync2;
`else
  assign sample = irq_src;
`endif

  assign set_vec = sample & ~prev;
  assign active  = pending & mask;
  assign ack_idx = lowest_idx(active);

  always_comb begin
    state_nxt = state;
    clr_vec   = '0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (|active) state_nxt = REQ;
      end
      REQ: begin
        if (!(|active)) begin
          state_nxt = IDLE;
        end else if (iack) begin
          ack       = 1'b1;
          clr_vec   = {{(NSRC-1){1'b0}}, 1'b1} << ack_idx;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        // Nothing new is offered until the handler returns.
        if (eoi) state_nxt = (|active) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      prev     <= '0;
      mask     <= '0;
      pending  <= '0;
      vec_addr <= VEC_BASE;
    end else begin
      state   <= state_nxt;
      prev    <= sample;
      // A new edge wins over an acknowledge of the same bit.
      pending <= (pending & ~clr_vec) | set_vec;
      if (mask_we) mask <= mask_in;
      if (ack) vec_addr <= VEC_BASE + 16'({ack_idx, 1'b0});
    end
  end

  assign irq        = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: vector table plus hand sequences for reset,
// latency and same-cycle set/clear corners.
module tb_int_ctrl;

`ifdef INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  irq_src = '0;
  logic        mask_we = 1'b0;
  logic [7:0]  mask_in = '0;
  logic        iack = 1'b0;
  logic        eoi = 1'b0;
  logic        irq;
  logic [15:0] vec_addr;
  logic        in_service;
  logic [7:0]  pending;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0]  src;
    logic        we;
    logic [7:0]  msk;
    logic        ack;
    logic        e;
    logic        lat;
    logic        x_irq;
    logic        x_svc;
    logic [7:0]  x_pend;
    logic [15:0] x_vec;
  } vec_t;

  vec_t tbl[$];

  int_ctrl #(.VEC_BASE(16'hFF00), .NSRC(8)) dut (
    .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .mask_we(mask_we),
    .mask_in(mask_in), .iack(iack), .eoi(eoi), .irq(irq), .vec_addr(vec_addr),
    .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic x_irq, input logic x_svc,
                         input logic [7:0] x_pend, input logic [15:0] x_vec);
    chk({tag, " irq"}, 16'(irq), 16'(x_irq));
    chk({tag, " in_service"}, 16'(in_service), 16'(x_svc));
    chk({tag, " pending"}, 16'(pending), 16'(x_pend));
    chk({tag, " vec_addr"}, vec_addr, x_vec);
  endtask

  // Drive one cycle of inputs and sample 1 time unit after the rising edge.
  task automatic step(input logic [7:0] s, input logic w, input logic [7:0] m,
                      input logic a, input logic e);
    irq_src = s; mask_we = w; mask_in = m; iack = a; eoi = e;
    @(posedge clk);
    #1;
    mask_we = 1'b0; iack = 1'b0; eoi = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    irq_src = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic [7:0] s, input logic w, input logic [7:0] m,
                     input logic a, input logic e, input logic l, input logic xi,
                     input logic xs, input logic [7:0] xp, input logic [15:0] xv);
    vec_t r;
    r.src = s; r.we = w; r.msk = m; r.ack = a; r.e = e; r.lat = l;
    r.x_irq = xi; r.x_svc = xs; r.x_pend = xp; r.x_vec = xv;
    tbl.push_back(r);
  endtask

  initial begin
    int cnt;
    //   src    we    mask   iack  eoi   lat   irq   svc   pend   vec
    row(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF00);
    row(8'h08, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 16'hFF00);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08, 16'hFF00);
    row(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hFF06);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hFF06);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF06);
    row(8'h24, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h24, 16'hFF06);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h24, 16'hFF06);
    row(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'hFF04);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 16'hFF04);
    row(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hFF0A);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF0A);
    row(8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF0A);
    row(8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 16'hFF0A);
    row(8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'hFF0A);
    row(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'hFF0A);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 16'hFF0A);
    row(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hFF00);
    row(8'h80, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 16'hFF00);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 16'hFF00);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 16'hFF00);
    row(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hFF0E);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF0E);
    row(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF0E);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF0E);
    row(8'h10, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 16'hFF0E);
    row(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 16'hFF0E);
    row(8'h00, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 16'hFF0E);
    row(8'h00, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 16'hFF0E);
    row(8'h00, 1'b0, 8'hEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 16'hFF0E);

    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 8'h00, 16'hFF00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].src, tbl[i].we, tbl[i].msk, tbl[i].ack, tbl[i].e);
      if (tbl[i].lat) repeat (LAT) step(tbl[i].src, 1'b0, tbl[i].msk, 1'b0, 1'b0);
      chk_out($sformatf("row%0d", i), tbl[i].x_irq, tbl[i].x_svc, tbl[i].x_pend, tbl[i].x_vec);
    end

    // Asynchronous reset while a handler is active and bit 4 is pending.
    step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
    chk_out("svc4", 1'b0, 1'b1, 8'h00, 16'hFF08);
    step(8'h10, 1'b0, 8'hFF, 1'b0, 1'b0);
    repeat (LAT) step(8'h10, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    chk_out("svc_pend", 1'b0, 1'b1, 8'h10, 16'hFF08);
    #2 reset_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 8'h00, 16'hFF00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Edge-to-irq latency on bit 1.
    step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    cnt = 0;
    while (irq !== 1'b1 && cnt < 10) begin
      step(8'h02, 1'b0, 8'hFF, 1'b0, 1'b0);
      cnt++;
    end
    chk("irq_latency", 16'(cnt), 16'(2 + LAT));

`ifndef INT_SYNC_EN
    // Same-cycle set/clear: same bit stays set, different bits both act.
    pulse_reset();
    step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(8'h08, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    chk_out("pre_same", 1'b1, 1'b0, 8'h08, 16'hFF00);
    step(8'h08, 1'b0, 8'hFF, 1'b1, 1'b0);
    chk_out("same_bit", 1'b0, 1'b1, 8'h08, 16'hFF06);
    step(8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);
    chk_out("eoi_req", 1'b1, 1'b0, 8'h08, 16'hFF06);
    step(8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);
    chk_out("diff_bit", 1'b0, 1'b1, 8'h02, 16'hFF06);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
